// File: rtl/axi_cdma_desc_split.sv
// Request front end for axi_cdma: splits copy requests into CHUNK_LEN
// descriptors, bounds the in-flight count and reports request completion.
module axi_cdma_desc_split #(
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 20,
  parameter int TAG_WIDTH       = 8,
  parameter int REQ_LEN_WIDTH   = 32,
  parameter int REQ_TAG_WIDTH   = 8,
  parameter int CHUNK_LEN       = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [AXI_ADDR_WIDTH-1:0] s_axis_req_read_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axis_req_write_addr,
  input  logic [REQ_LEN_WIDTH-1:0]  s_axis_req_len,
  input  logic [REQ_TAG_WIDTH-1:0]  s_axis_req_tag,
  input  logic                      s_axis_req_valid,
  output logic                      s_axis_req_ready,

  output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_read_addr,
  output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_write_addr,
  output logic [LEN_WIDTH-1:0]      m_axis_desc_len,
  output logic [TAG_WIDTH-1:0]      m_axis_desc_tag,
  output logic                      m_axis_desc_valid,
  input  logic                      m_axis_desc_ready,

  input  logic [TAG_WIDTH-1:0]      s_axis_desc_status_tag,
  input  logic                      s_axis_desc_status_valid,

  output logic [REQ_TAG_WIDTH-1:0]  m_axis_req_status_tag,
  output logic                      m_axis_req_status_valid,

  output logic                      busy
);

  localparam logic [REQ_LEN_WIDTH-1:0] CHUNK =
    REQ_LEN_WIDTH'(CHUNK_LEN);
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AXI_ADDR_WIDTH-1:0] rd_ptr;
  logic [AXI_ADDR_WIDTH-1:0] wr_ptr;
  logic [REQ_LEN_WIDTH-1:0]  remaining;
  logic [REQ_LEN_WIDTH-1:0]  chunk;
  logic [REQ_TAG_WIDTH-1:0]  req_tag;
  logic [REQ_TAG_WIDTH-1:0]  done_tag;
  logic [TAG_WIDTH-1:0]      seq;
  logic [7:0]                outstanding;
  logic [7:0]                outstanding_nxt;
  logic                      done;
  logic                      done_set;
  logic                      req_hs;
  logic                      desc_hs;
  logic                      zero_req;
  logic                      last_chunk;
  logic                      status_tag_unused;

  // CDMA status tags carry no information we need; completions
  // are counted, not matched.
  assign status_tag_unused = ^s_axis_desc_status_tag;

  assign req_hs     = s_axis_req_valid && s_axis_req_ready;
  assign desc_hs    = m_axis_desc_valid && m_axis_desc_ready;
  assign zero_req   = s_axis_req_len == '0;
  assign chunk      = (remaining < CHUNK) ? remaining : CHUNK;
  assign last_chunk = remaining <= CHUNK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A status coinciding with an issue cancels out; never underflow.
  always_comb begin
    outstanding_nxt = outstanding;
    if (state != IDLE) begin
      if (desc_hs && !s_axis_desc_status_valid) begin
        outstanding_nxt = outstanding + 8'd1;
      end else if (!desc_hs && s_axis_desc_status_valid &&
                   outstanding != 8'd0) begin
        outstanding_nxt = outstanding - 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_hs) begin
          if (zero_req) begin
            done_set = 1'b1;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (desc_hs && last_chunk) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_nxt == 8'd0) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    s_axis_req_ready        = (state == IDLE) && !rst;
    m_axis_desc_valid       = (state == ISSUE) &&
                              (outstanding < MAX_OUT);
    m_axis_desc_read_addr   = rd_ptr;
    m_axis_desc_write_addr  = wr_ptr;
    m_axis_desc_len         = LEN_WIDTH'(chunk);
    m_axis_desc_tag         = seq;
    m_axis_req_status_valid = done;
    m_axis_req_status_tag   = done_tag;
    busy                    = state != IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      remaining   <= '0;
      req_tag     <= '0;
      done_tag    <= '0;
      seq         <= '0;
      outstanding <= '0;
      done        <= 1'b0;
    end else begin
      done        <= done_set;
      outstanding <= outstanding_nxt;
      if (req_hs) begin
        rd_ptr      <= s_axis_req_read_addr;
        wr_ptr      <= s_axis_req_write_addr;
        remaining   <= s_axis_req_len;
        req_tag     <= s_axis_req_tag;
        seq         <= '0;
        outstanding <= '0;
      end
      if (desc_hs) begin
        rd_ptr    <= rd_ptr + AXI_ADDR_WIDTH'(chunk);
        wr_ptr    <= wr_ptr + AXI_ADDR_WIDTH'(chunk);
        remaining <= remaining - chunk;
        seq       <= seq + TAG_WIDTH'(1);
      end
      if (done_set) begin
        done_tag <= (state == IDLE) ? s_axis_req_tag : req_tag;
      end
    end
  end

endmodule

// File: tb/tb_axi_cdma_desc_split.sv
// Bench for axi_cdma_desc_split: a CDMA responder plus an arithmetic
// model of the expected descriptor stream and completion timing.
`timescale 1ns/1ps
module tb_axi_cdma_desc_split;
  localparam int AW  = 16;
  localparam int LW  = 20;
  localparam int TW  = 8;
  localparam int RLW = 32;
  localparam int RTW = 8;
  localparam int CL  = 4096;
  localparam int MO  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  s_axis_req_read_addr;
  logic [AW-1:0]  s_axis_req_write_addr;
  logic [RLW-1:0] s_axis_req_len;
  logic [RTW-1:0] s_axis_req_tag;
  logic           s_axis_req_valid;
  logic           s_axis_req_ready;
  logic [AW-1:0]  m_axis_desc_read_addr;
  logic [AW-1:0]  m_axis_desc_write_addr;
  logic [LW-1:0]  m_axis_desc_len;
  logic [TW-1:0]  m_axis_desc_tag;
  logic           m_axis_desc_valid;
  logic           m_axis_desc_ready;
  logic [TW-1:0]  s_axis_desc_status_tag;
  logic           s_axis_desc_status_valid;
  logic [RTW-1:0] m_axis_req_status_tag;
  logic           m_axis_req_status_valid;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int obs_cmpl;
  logic [AW-1:0] obs_rd[$];
  logic [AW-1:0] obs_wr[$];
  logic [LW-1:0] obs_len[$];
  logic [TW-1:0] obs_tag[$];

  always #5 clk = ~clk;

  axi_cdma_desc_split #(
    .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
    .REQ_LEN_WIDTH(RLW), .REQ_TAG_WIDTH(RTW),
    .CHUNK_LEN(CL), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_req_read_addr(s_axis_req_read_addr),
    .s_axis_req_write_addr(s_axis_req_write_addr),
    .s_axis_req_len(s_axis_req_len),
    .s_axis_req_tag(s_axis_req_tag),
    .s_axis_req_valid(s_axis_req_valid),
    .s_axis_req_ready(s_axis_req_ready),
    .m_axis_desc_read_addr(m_axis_desc_read_addr),
    .m_axis_desc_write_addr(m_axis_desc_write_addr),
    .m_axis_desc_len(m_axis_desc_len),
    .m_axis_desc_tag(m_axis_desc_tag),
    .m_axis_desc_valid(m_axis_desc_valid),
    .m_axis_desc_ready(m_axis_desc_ready),
    .s_axis_desc_status_tag(s_axis_desc_status_tag),
    .s_axis_desc_status_valid(s_axis_desc_status_valid),
    .m_axis_req_status_tag(m_axis_req_status_tag),
    .m_axis_req_status_valid(m_axis_req_status_valid),
    .busy(busy)
  );

  task automatic idle_inputs();
    s_axis_req_read_addr     = '0;
    s_axis_req_write_addr    = '0;
    s_axis_req_len           = '0;
    s_axis_req_tag           = '0;
    s_axis_req_valid         = 1'b0;
    m_axis_desc_ready        = 1'b0;
    s_axis_desc_status_tag   = '0;
    s_axis_desc_status_valid = 1'b0;
  endtask

  // One request end to end. Expected descriptors come from plain
  // arithmetic on the request; the responder answers each issued
  // descriptor after a random delay, one status per cycle.
  task automatic run_req(input logic [AW-1:0] ra,
                         input logic [AW-1:0] wa,
                         input logic [RLW-1:0] len,
                         input logic [RTW-1:0] tg,
                         input int rdy_pct, input int dmin,
                         input int dmax, input int low_after,
                         input int low_cnt);
    longint total, issued, outs, now, last_due, rem, d;
    longint due[$];
    bit active, pend, seen, st, rdy, hs, exp_v;
    int hold;
    logic [AW-1:0] e_rd, e_wr;
    logic [LW-1:0] e_len;
    logic [TW-1:0] e_tag;
    total = (longint'(len) + CL - 1) / CL;
    issued = 0; outs = 0; last_due = 0; hold = 0;
    seen = 0; obs_cmpl = 0;
    obs_rd.delete(); obs_wr.delete();
    obs_len.delete(); obs_tag.delete();
    @(posedge clk); #1;
    s_axis_req_read_addr  = ra;
    s_axis_req_write_addr = wa;
    s_axis_req_len        = len;
    s_axis_req_tag        = tg;
    s_axis_req_valid      = 1'b1;
    m_axis_desc_ready     = 1'b0;
    s_axis_desc_status_valid = 1'b0;
    #1;
    checks++;
    if (s_axis_req_ready !== 1'b1 || m_axis_desc_valid !== 1'b0 ||
        m_axis_req_status_valid !== 1'b0)
      begin
      errors++;
      $display("FAIL accept_cycle ready=%b dvalid=%b cmpl=%b req 1 0 0",
               s_axis_req_ready, m_axis_desc_valid,
               m_axis_req_status_valid);
    end
    active = total > 0;
    pend = total == 0;
    now = 1;
    while (!seen && now < 3000) begin
      @(posedge clk); #1;
      s_axis_req_valid = 1'b0;
      st = 0;
      if (due.size() > 0 && due[0] <= now) begin
        st = 1;
        void'(due.pop_front());
      end
      s_axis_desc_status_valid = st;
      s_axis_desc_status_tag   = TW'($urandom);
      if (hold > 0) begin
        rdy = 0;
        hold--;
      end else begin
        rdy = $urandom_range(99) < rdy_pct;
      end
      m_axis_desc_ready = rdy;
      #1;
      checks++;
      if (m_axis_req_status_valid !== pend) begin
        errors++;
        $display("FAIL cmpl_valid cycle=%0d got=%b exp=%b",
                 now, m_axis_req_status_valid, pend);
      end
      if (m_axis_req_status_valid === 1'b1) obs_cmpl++;
      if (pend) begin
        seen = 1;
        checks++;
        if (m_axis_req_status_tag !== tg) begin
          errors++;
          $display("FAIL cmpl_tag got=%h exp=%h",
                   m_axis_req_status_tag, tg);
        end
      end
      checks++;
      if (busy !== active || s_axis_req_ready !== !active) begin
        errors++;
        $display("FAIL busy_ready cycle=%0d busy=%b ready=%b exp_busy=%b",
                 now, busy, s_axis_req_ready, active);
      end
      exp_v = active && issued < total && outs < MO;
      checks++;
      if (m_axis_desc_valid !== exp_v) begin
        errors++;
        $display("FAIL desc_valid cycle=%0d got=%b exp=%b",
                 now, m_axis_desc_valid, exp_v);
      end
      if (m_axis_desc_valid === 1'b1 && issued < total) begin
        rem   = longint'(len) - issued * CL;
        e_len = LW'(rem < CL ? rem : longint'(CL));
        e_rd  = AW'(longint'(ra) + issued * CL);
        e_wr  = AW'(longint'(wa) + issued * CL);
        e_tag = TW'(issued);
        checks++;
        if (m_axis_desc_read_addr !== e_rd ||
            m_axis_desc_write_addr !== e_wr ||
            m_axis_desc_len !== e_len || m_axis_desc_tag !== e_tag)
          begin
          errors++;
          $display("FAIL desc_fields n=%0d got=%h/%h/%0d/%0d exp=%h/%h/%0d/%0d",
                   issued, m_axis_desc_read_addr,
                   m_axis_desc_write_addr, m_axis_desc_len,
                   m_axis_desc_tag, e_rd, e_wr, e_len, e_tag);
        end
      end
      pend = 0;
      hs = m_axis_desc_valid === 1'b1 && rdy;
      if (hs) begin
        obs_rd.push_back(m_axis_desc_read_addr);
        obs_wr.push_back(m_axis_desc_write_addr);
        obs_len.push_back(m_axis_desc_len);
        obs_tag.push_back(m_axis_desc_tag);
      end
      if (active) begin
        if (hs && !st) outs++;
        else if (!hs && st && outs > 0) outs--;
        if (hs) begin
          issued++;
          d = $urandom_range(dmax, dmin);
          last_due = (now + d > last_due + 1) ? now + d : last_due + 1;
          due.push_back(last_due);
          if (issued == low_after) hold = low_cnt;
        end
        if (issued >= total && outs == 0) begin
          active = 0;
          pend = 1;
        end
      end
      now++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout len=%0d issued=%0d got=no_completion exp=completion",
               len, issued);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_axis_req_ready !== 1'b0 || m_axis_desc_valid !== 1'b0 ||
        m_axis_req_status_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ready=%b dv=%b sv=%b busy=%b exp 0000",
               s_axis_req_ready, m_axis_desc_valid,
               m_axis_req_status_valid, busy);
    end
    checks++;
    if (m_axis_desc_read_addr !== 0 || m_axis_desc_write_addr !== 0 ||
        m_axis_desc_len !== 0 || m_axis_desc_tag !== 0 ||
        m_axis_req_status_tag !== 0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0",
               m_axis_desc_read_addr, m_axis_desc_write_addr,
               m_axis_desc_len, m_axis_desc_tag, m_axis_req_status_tag);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_axis_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready got=%b exp=1", s_axis_req_ready);
    end
  endtask

  task automatic test_single();
    run_req(16'h1000, 16'h8000, 32'd10000, 8'h3C, 100, 2, 2, 0, 0);
    checks++;
    if (obs_rd.size() != 3) begin
      errors++;
      $display("FAIL single_count got=%0d exp=3", obs_rd.size());
    end else begin
      checks++;
      if (obs_rd[0] !== 16'h1000 || obs_wr[0] !== 16'h8000 ||
          obs_len[0] !== 20'd4096 || obs_tag[0] !== 8'd0 ||
          obs_rd[1] !== 16'h2000 || obs_wr[1] !== 16'h9000 ||
          obs_len[1] !== 20'd4096 || obs_tag[1] !== 8'd1 ||
          obs_rd[2] !== 16'h3000 || obs_wr[2] !== 16'hA000 ||
          obs_len[2] !== 20'd1808 || obs_tag[2] !== 8'd2) begin
        errors++;
        $display("FAIL single_list got_last=%h/%h/%0d/%0d exp=3000/a000/1808/2",
                 obs_rd[2], obs_wr[2], obs_len[2], obs_tag[2]);
      end
    end
    checks++;
    if (obs_cmpl != 1) begin
      errors++;
      $display("FAIL single_cmpl got=%0d exp=1", obs_cmpl);
    end
  endtask

  task automatic test_wrap();
    run_req(16'hF000, 16'h7000, 32'd8192, 8'h21, 100, 1, 3, 0, 0);
    checks++;
    if (obs_rd.size() != 2 || obs_rd[1] !== 16'h0000 ||
        obs_wr[1] !== 16'h8000) begin
      errors++;
      $display("FAIL wrap got_n=%0d rd1=%h exp_n=2 rd1=0000",
               obs_rd.size(), obs_rd.size() > 1 ? obs_rd[1] : 16'hxxxx);
    end
  endtask

  task automatic test_zero();
    run_req(16'h1234, 16'h5678, 32'd0, 8'h5A, 100, 1, 1, 0, 0);
    checks++;
    if (obs_rd.size() != 0 || obs_cmpl != 1) begin
      errors++;
      $display("FAIL zero_len descs=%0d cmpl=%0d exp 0 1",
               obs_rd.size(), obs_cmpl);
    end
  endtask

  task automatic test_backpressure();
    run_req(16'h4000, 16'hC000, 32'd12288, 8'h99, 100, 6, 6, 1, 5);
    checks++;
    if (obs_rd.size() != 3 || obs_cmpl != 1) begin
      errors++;
      $display("FAIL backpressure descs=%0d cmpl=%0d exp 3 1",
               obs_rd.size(), obs_cmpl);
    end
  endtask

  task automatic test_throttle();
    int cnt;
    cnt = 0;
    @(posedge clk); #1;
    s_axis_req_read_addr  = 16'h2000;
    s_axis_req_write_addr = 16'h6000;
    s_axis_req_len        = 32'd32768;
    s_axis_req_tag        = 8'h11;
    s_axis_req_valid      = 1'b1;
    m_axis_desc_ready     = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      s_axis_req_valid = 1'b0;
      #1;
      if (m_axis_desc_valid === 1'b1) cnt++;
    end
    checks++;
    if (cnt != MO || m_axis_desc_valid !== 1'b0) begin
      errors++;
      $display("FAIL throttle_cap issued=%0d valid=%b exp %0d 0",
               cnt, m_axis_desc_valid, MO);
    end
    @(posedge clk); #1;
    s_axis_desc_status_valid = 1'b1;
    #1;
    checks++;
    if (m_axis_desc_valid !== 1'b0) begin
      errors++;
      $display("FAIL throttle_hold valid got=%b exp=0", m_axis_desc_valid);
    end
    @(posedge clk); #1;
    s_axis_desc_status_valid = 1'b0;
    #1;
    checks++;
    if (m_axis_desc_valid !== 1'b1 || m_axis_desc_tag !== 8'd4) begin
      errors++;
      $display("FAIL throttle_release valid=%b tag=%0d exp 1 4",
               m_axis_desc_valid, m_axis_desc_tag);
    end
    @(posedge clk); #2;
    checks++;
    if (m_axis_desc_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL throttle_refill valid=%b busy=%b exp 0 1",
               m_axis_desc_valid, busy);
    end
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || s_axis_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL throttle_reset busy=%b ready=%b exp 0 1",
               busy, s_axis_req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    @(posedge clk); #1;
    s_axis_req_read_addr  = 16'h0800;
    s_axis_req_write_addr = 16'h3000;
    s_axis_req_len        = 32'd20000;
    s_axis_req_tag        = 8'h77;
    s_axis_req_valid      = 1'b1;
    m_axis_desc_ready     = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      s_axis_req_valid = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_axis_desc_status_valid = 1'b1;
      #1;
      if (m_axis_desc_valid !== 1'b0 || m_axis_req_status_valid !== 1'b0 ||
          busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_idle bad_cycles=%0d exp=0", bad);
    end
    run_req(16'h0100, 16'h0200, 32'd100, 8'h42, 100, 3, 3, 0, 0);
    checks++;
    if (obs_rd.size() != 1 || obs_tag[0] !== 8'd0 ||
        obs_len[0] !== 20'd100 || obs_cmpl != 1) begin
      errors++;
      $display("FAIL reset_mid_after descs=%0d cmpl=%0d exp 1 1",
               obs_rd.size(), obs_cmpl);
    end
  endtask

  task automatic test_back_to_back();
    run_req(16'hA000, 16'h1000, 32'd4097, 8'h01, 100, 1, 1, 0, 0);
    run_req(16'h0000, 16'h0000, 32'd0, 8'h02, 100, 1, 1, 0, 0);
    run_req(16'hB000, 16'h2000, 32'd4096, 8'h03, 100, 1, 2, 0, 0);
    checks++;
    if (obs_rd.size() != 1 || obs_len[0] !== 20'd4096) begin
      errors++;
      $display("FAIL b2b_exact descs=%0d exp=1 len=4096", obs_rd.size());
    end
  endtask

  task automatic test_random();
    logic [RLW-1:0] len;
    int mode, dmin;
    for (int i = 0; i < 12; i++) begin
      mode = $urandom_range(5);
      unique case (mode)
        0: len = 0;
        1: len = CL;
        2: len = CL + 1;
        3: len = RLW'(CL * $urandom_range(1, 6));
        default: len = RLW'($urandom_range(1, 40000));
      endcase
      dmin = $urandom_range(1, 4);
      run_req(AW'($urandom), AW'($urandom), len, RTW'($urandom),
              $urandom_range(40, 100), dmin,
              dmin + $urandom_range(0, 6), 0, 0);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_wrap();
    test_zero();
    test_backpressure();
    test_throttle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
